// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered NCH-to-1 packet-atomic valid/ready mux, fixed or round-robin select; STREAM_MUX_STATS_EN adds pkt_cnt
module stream_mux_rr #(
  parameter int W   = 4,
  parameter int NCH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH*W-1:0]         in_data,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH-1:0]           in_last,
  output logic [NCH-1:0]           in_ready,
  input  logic                     sel_mode,
  input  logic [$clog2(NCH)-1:0]   sel_fixed,
  output logic [W-1:0]             out_data,
  output logic                     out_last,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef STREAM_MUX_STATS_EN
  ,
  output logic [15:0]              pkt_cnt
`endif
);
  localparam int CW = $clog2(NCH);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  ch_q, ch_d, rr_q, rr_d, out_ch_q, out_ch_d, gnt, cand;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic           gnt_ok, space, xfer;
  always_comb begin
    gnt    = ch_q;
    gnt_ok = 1'b1;
    cand   = '0;
    if (state_q == IDLE) begin
      gnt    = sel_fixed;
      gnt_ok = ({1'b0, sel_fixed} < (CW+1)'(NCH)) && in_valid[sel_fixed];
      if (sel_mode) begin
        gnt_ok = 1'b0;
        for (int i = NCH-1; i >= 0; i--) begin
          cand = CW'((int'(rr_q) + i) % NCH);
          if (in_valid[cand]) begin
            gnt    = cand;
            gnt_ok = 1'b1;
          end
        end
      end
    end
  end
  assign space    = !out_valid_q || out_ready;
  assign xfer     = rst_n && gnt_ok && space && in_valid[gnt];
  assign in_ready = (rst_n && gnt_ok && space) ? NCH'(1) << gnt : '0;
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    rr_d        = rr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    out_valid_d = xfer || (out_valid_q && !out_ready);
    if (xfer) begin
      out_data_d = in_data[gnt*W +: W];
      out_last_d = in_last[gnt];
      out_ch_d   = gnt;
      ch_d       = gnt;
      state_d    = in_last[gnt] ? IDLE : LOCK;
      rr_d       = in_last[gnt] ? ((gnt == CW'(NCH-1)) ? '0 : gnt + 1'b1) : rr_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      rr_q        <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      rr_q        <= rr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
`ifdef STREAM_MUX_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  assign pkt_cnt_d = (out_valid_q && out_ready && out_last_q && pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end
  assign pkt_cnt = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: vector table, corner sequences and queue-based random model for stream_mux_rr
module tb_stream_mux_rr;
  localparam int NCH = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in_data = '0;
  logic [3:0]  in_valid = '0, in_last = '0, in_ready;
  logic        sel_mode = 1'b0;
  logic [1:0]  sel_fixed = '0;
  logic [3:0]  out_data;
  logic        out_last, out_valid;
  logic [1:0]  out_ch;
  logic        out_ready = 1'b1;
`ifdef STREAM_MUX_STATS_EN
  logic [15:0] pkt_cnt;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  stream_mux_rr #(.W(4), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sel_mode(sel_mode), .sel_fixed(sel_fixed), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
`ifdef STREAM_MUX_STATS_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );
  typedef struct {
    logic [3:0] v, l; logic m; logic [1:0] f; logic [15:0] d;
    logic [3:0] rdy; logic ov; logic [3:0] od; logic ol; logic [1:0] oc;
  } vec_t;
  typedef struct { logic [3:0] d; logic l; int c; } beat_t;
  vec_t  tv[7];
  beat_t q[$], got[$];
  int    m_owner = -1, m_rr = 0, m_pkts = 0;
  logic [3:0] sv[7], sl[7], sd[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic m_reset();
    q.delete();
    m_owner = -1;
    m_rr = 0;
    m_pkts = 0;
  endtask
  function automatic int m_gnt();
    int c;
    if (m_owner >= 0) return m_owner;
    if (!sel_mode) return in_valid[sel_fixed] ? int'(sel_fixed) : -1;
    for (int k = 0; k < NCH; k++) begin
      c = (m_rr + k) % NCH;
      if (in_valid[c[1:0]]) return c;
    end
    return -1;
  endfunction
  function automatic logic [3:0] m_rdy();
    int g = m_gnt();
    if (g < 0 || !(q.size() == 0 || out_ready) || !rst_n) return 4'h0;
    return 4'(1) << g;
  endfunction
  task automatic m_clock();
    int g = m_gnt();
    bit sp = (q.size() == 0) || out_ready;
    bit xf = (g >= 0) && sp && in_valid[g[1:0]];
    beat_t b;
    if (q.size() != 0 && out_ready) begin
      if (q[0].l) m_pkts++;
      void'(q.pop_front());
    end
    if (xf) begin
      b.d = 4'(in_data >> (4*g));
      b.l = in_last[g[1:0]];
      b.c = g;
      q.push_back(b);
      if (b.l) begin
        m_owner = -1;
        m_rr = (g + 1) % NCH;
      end else m_owner = g;
    end
  endtask
  task automatic check_out();
    if (q.size() != 0) begin
      chk("rnd_ov", out_valid, 1);
      chk("rnd_od", out_data, q[0].d);
      chk("rnd_ol", out_last, q[0].l);
      chk("rnd_oc", out_ch, q[0].c[1:0]);
    end else chk("rnd_ov", out_valid, 0);
  endtask
  task automatic tick();
    #1;
    chk("rnd_rdy", in_ready, m_rdy());
    m_clock();
    @(negedge clk);
    check_out();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    in_last = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask
  initial begin
    tv[0] = '{4'hF, 4'hF, 1'b0, 2'd2, 16'hC4E7, 4'b0100, 1'b1, 4'h4, 1'b1, 2'd2};
    tv[1] = '{4'hB, 4'hF, 1'b0, 2'd2, 16'hC4E7, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0};
    tv[2] = '{4'hF, 4'hF, 1'b1, 2'd0, 16'hC4E7, 4'b0001, 1'b1, 4'h7, 1'b1, 2'd0};
    tv[3] = '{4'hC, 4'hF, 1'b1, 2'd0, 16'hC4E7, 4'b0100, 1'b1, 4'h4, 1'b1, 2'd2};
    tv[4] = '{4'h0, 4'hF, 1'b1, 2'd1, 16'hC4E7, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0};
    tv[5] = '{4'h8, 4'h0, 1'b0, 2'd3, 16'hC4E7, 4'b1000, 1'b1, 4'hC, 1'b0, 2'd3};
    tv[6] = '{4'h2, 4'h0, 1'b1, 2'd0, 16'hC4E7, 4'b0010, 1'b1, 4'hE, 1'b0, 2'd1};
    sv = '{4'b0010, 4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0001, 4'b0000};
    sl = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000};
    sd = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h3};
    #2;
    rst_n = 1'b0;
    in_valid = 4'hF;
    in_last = 4'hF;
    sel_mode = 1'b1;
    #1;
    chk("rst_rdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_oc", out_ch, 0);
    chk("rst_ol", out_last, 0);
    for (int i = 0; i < 7; i++) begin
      do_reset();
      sel_mode = tv[i].m;
      sel_fixed = tv[i].f;
      in_valid = tv[i].v;
      in_last = tv[i].l;
      in_data = tv[i].d;
      #1;
      chk("vec_rdy", in_ready, tv[i].rdy);
      @(negedge clk);
      chk("vec_ov", out_valid, tv[i].ov);
      chk("vec_od", out_data, tv[i].od);
      chk("vec_ol", out_last, tv[i].ol);
      chk("vec_oc", out_ch, tv[i].oc);
    end
    do_reset();
    sel_mode = 1'b1;
    in_valid = 4'hF;
    in_last = 4'hF;
    in_data = 16'hC4E7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_ov", out_valid, 1);
      chk("rr_ch", out_ch, i % 4);
    end
    do_reset();
    sel_mode = 1'b1;
    got.delete();
    for (int c = 0; c < 7; c++) begin
      in_valid = sv[c];
      in_last = sl[c];
      in_data = {8'h00, sd[c], 4'h9};
      #1;
      if (c >= 1 && c <= 4) chk("atomic_rdy", in_ready, 4'b0010);
      @(negedge clk);
      if (out_valid) got.push_back('{out_data, out_last, int'(out_ch)});
    end
    chk("atomic_n", got.size(), 4);
    if (got.size() == 4) begin
      chk("atomic_b1", {got[0].c[3:0], got[0].d, 3'b0, got[0].l}, 12'h110);
      chk("atomic_b2", {got[1].c[3:0], got[1].d, 3'b0, got[1].l}, 12'h120);
      chk("atomic_b3", {got[2].c[3:0], got[2].d, 3'b0, got[2].l}, 12'h131);
      chk("atomic_b4", {got[3].c[3:0], got[3].d, 3'b0, got[3].l}, 12'h091);
    end
    do_reset();
    sel_mode = 1'b0;
    sel_fixed = 2'd0;
    in_valid = 4'b0001;
    in_last = 4'b0001;
    in_data = 16'h0005;
    out_ready = 1'b0;
    #1;
    chk("bp_rdy0", in_ready, 4'b0001);
    @(negedge clk);
    chk("bp_od0", out_data, 4'h5);
    chk("bp_ov0", out_valid, 1);
    in_data = 16'h0006;
    repeat (3) begin
      #1;
      chk("bp_rdy", in_ready, 0);
      @(negedge clk);
      chk("bp_od", out_data, 4'h5);
      chk("bp_oc", out_ch, 0);
      chk("bp_ol", out_last, 1);
      chk("bp_ov", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy1", in_ready, 4'b0001);
    @(negedge clk);
    chk("bp_od1", out_data, 4'h6);
    in_data = 16'h0007;
    #1;
    chk("bp_rdy2", in_ready, 4'b0001);
    @(negedge clk);
    chk("bp_od2", out_data, 4'h7);
    do_reset();
    sel_mode = 1'b1;
    in_valid = 4'b0010;
    in_last = 4'b0000;
    in_data = 16'h0030;
    @(negedge clk);
    chk("mrst_pre_ov", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_rdy", in_ready, 0);
    chk("mrst_od", out_data, 0);
    chk("mrst_oc", out_ch, 0);
    chk("mrst_ol", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 4'hF;
    in_last = 4'hF;
    #1;
    chk("mrst_rdy1", in_ready, 4'b0001);
    @(negedge clk);
    chk("mrst_oc1", out_ch, 0);
    chk("mrst_ov1", out_valid, 1);
    do_reset();
    sel_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) sel_mode = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) sel_fixed = 2'($urandom_range(3));
      in_valid = 4'($urandom);
      in_last = 4'($urandom) & 4'($urandom);
      in_data = 16'($urandom);
      out_ready = $urandom_range(9) < 7;
      tick();
    end
`ifdef STREAM_MUX_STATS_EN
    chk("pkt_cnt", pkt_cnt, (m_pkts > 65535) ? 65535 : m_pkts);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
